// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch stage and control unit: opcode field layout,
// CU opcode values and the fetch FSM state encoding.
package pc_fetch_unit_pkg;

    localparam int OPCODE_WIDTH = 4;

    localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = 4'h0;
    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = 4'h1;
    localparam logic [OPCODE_WIDTH-1:0] OP_STORE = 4'h2;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = 4'h3;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB   = 4'h4;
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP   = 4'h5;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRZ   = 4'h6;
    localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_READY = 2'd2
    } fetch_state_t;

    // The CU must never act on a stale IR, so an invalid IR reads as NOP.
    function automatic logic [OPCODE_WIDTH-1:0] gate_opcode(
        input logic                    valid,
        input logic [OPCODE_WIDTH-1:0] op
    );
        return valid ? op : OP_NOP;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_pc_reg.sv
// Program counter register: async clear, load from immediate, increment with
// natural wrap at 2^PC_WIDTH. Load has priority over increment.
module pc_reg #(
    parameter int PC_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                inc,
    input  logic [PC_WIDTH-1:0] load_value,
    output logic [PC_WIDTH-1:0] pc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC and instruction-fetch stage: fetches one word per request over a req/ack
// handshake into the IR and redirects the PC on CU incPC/loadFromI commands.
import pc_fetch_unit_pkg::*;

module pc_fetch_unit #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    incPC,
    input  logic                    loadFromI,
    output logic [PC_WIDTH-1:0]     imem_addr,
    output logic                    imem_req,
    input  logic                    imem_ack,
    input  logic [INSTR_WIDTH-1:0]  imem_rdata,
    output logic [OPCODE_WIDTH-1:0] opcode,
    output logic [PC_WIDTH-1:0]     imm,
    output logic                    instr_valid,
    output logic [PC_WIDTH-1:0]     pc
);

    fetch_state_t           state;
    logic [INSTR_WIDTH-1:0] ir;
    logic                   pc_load;
    logic                   pc_inc;
    logic                   unused_ir;

    // Commands are only honoured in READY; FETCH keeps the address stable.
    assign pc_load = (state == ST_READY) && loadFromI;
    assign pc_inc  = (state == ST_READY) && incPC;

    pc_reg #(
        .PC_WIDTH(PC_WIDTH)
    ) u_pc_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (pc_load),
        .inc       (pc_inc),
        .load_value(ir[PC_WIDTH-1:0]),
        .pc        (pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            ir          <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state    <= ST_FETCH;
                    imem_req <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir          <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (loadFromI || incPC) begin
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= ST_FETCH;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    instr_valid <= 1'b0;
                    imem_req    <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr = pc;
    assign opcode    = gate_opcode(instr_valid, ir[INSTR_WIDTH-1 -: OPCODE_WIDTH]);
    assign imm       = ir[PC_WIDTH-1:0];

    // IR bits between the opcode and the immediate are reserved for the CU.
    assign unused_ir = ^ir;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit with hand-computed expectations.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        incPC = 1'b0;
    logic        loadFromI = 1'b0;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic [3:0]  opcode;
    logic [7:0]  imm;
    logic        instr_valid;
    logic [7:0]  pc;

    int checks = 0;
    int errors = 0;

    pc_fetch_unit #(
        .PC_WIDTH(8),
        .INSTR_WIDTH(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .incPC      (incPC),
        .loadFromI  (loadFromI),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .opcode     (opcode),
        .imm        (imm),
        .instr_valid(instr_valid),
        .pc         (pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic inc, input logic load, input logic ack,
                                 input logic [15:0] rdata);
        incPC      = inc;
        loadFromI  = load;
        imem_ack   = ack;
        imem_rdata = rdata;
    endtask

    task automatic test_reset();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({imem_req, instr_valid, pc, opcode, imm, imem_addr} !== 30'h0) begin
            errors++;
            $display("[TB] FAIL reset_state: got req=%b valid=%b pc=%h op=%h imm=%h addr=%h expected all zero",
                     imem_req, instr_valid, pc, opcode, imm, imem_addr);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({imem_req, instr_valid, imem_addr} !== {1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("[TB] FAIL first_req: got req=%b valid=%b addr=%h expected req=1 valid=0 addr=00",
                     imem_req, instr_valid, imem_addr);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h1234);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if ({imem_req, instr_valid, opcode, imm, pc} !== {1'b0, 1'b1, 4'h1, 8'h34, 8'h00}) begin
            errors++;
            $display("[TB] FAIL first_instr: got req=%b valid=%b op=%h imm=%h pc=%h expected req=0 valid=1 op=1 imm=34 pc=00",
                     imem_req, instr_valid, opcode, imm, pc);
        end
    endtask

    task automatic test_ack_delay();
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'hDEAD);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({imem_req, imem_addr, instr_valid, opcode, imm} !== {1'b1, 8'h01, 1'b0, 4'h0, 8'h34}) begin
                errors++;
                $display("[TB] FAIL wait_cycle_%0d: got req=%b addr=%h valid=%b op=%h imm=%h expected req=1 addr=01 valid=0 op=0 imm=34",
                         i, imem_req, imem_addr, instr_valid, opcode, imm);
            end
            if (i < 3) tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h2ABC);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if ({imem_req, instr_valid, opcode, imm, pc} !== {1'b0, 1'b1, 4'h2, 8'hBC, 8'h01}) begin
            errors++;
            $display("[TB] FAIL delayed_load: got req=%b valid=%b op=%h imm=%h pc=%h expected req=0 valid=1 op=2 imm=BC pc=01",
                     imem_req, instr_valid, opcode, imm, pc);
        end
    endtask

    task automatic test_pc_wrap();
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        tick();
        checks++;
        if ({pc, imem_req, imem_addr} !== {8'hBC, 1'b1, 8'hBC}) begin
            errors++;
            $display("[TB] FAIL load_bc: got pc=%h req=%b addr=%h expected pc=BC req=1 addr=BC",
                     pc, imem_req, imem_addr);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h10FF);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h4011);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if ({pc, instr_valid, opcode} !== {8'hFF, 1'b1, 4'h4}) begin
            errors++;
            $display("[TB] FAIL at_ff: got pc=%h valid=%b op=%h expected pc=FF valid=1 op=4",
                     pc, instr_valid, opcode);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if ({pc, instr_valid, imem_req, imem_addr, opcode} !== {8'h00, 1'b0, 1'b1, 8'h00, 4'h0}) begin
            errors++;
            $display("[TB] FAIL pc_wrap: got pc=%h valid=%b req=%b addr=%h op=%h expected pc=00 valid=0 req=1 addr=00 op=0",
                     pc, instr_valid, imem_req, imem_addr, opcode);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h30A5);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic test_priority();
        checks++;
        if ({instr_valid, opcode, imm} !== {1'b1, 4'h3, 8'hA5}) begin
            errors++;
            $display("[TB] FAIL ir_30a5: got valid=%b op=%h imm=%h expected valid=1 op=3 imm=A5",
                     instr_valid, opcode, imm);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if ({pc, imem_req, imem_addr, instr_valid} !== {8'hA5, 1'b1, 8'hA5, 1'b0}) begin
            errors++;
            $display("[TB] FAIL load_priority: got pc=%h req=%b addr=%h valid=%b expected pc=A5 req=1 addr=A5 valid=0",
                     pc, imem_req, imem_addr, instr_valid);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h5007);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic test_reset_mid_fetch();
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if ({pc, imem_req} !== {8'hA6, 1'b1}) begin
            errors++;
            $display("[TB] FAIL pre_reset_fetch: got pc=%h req=%b expected pc=A6 req=1", pc, imem_req);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({imem_req, pc, instr_valid, imem_addr} !== {1'b0, 8'h00, 1'b0, 8'h00}) begin
            errors++;
            $display("[TB] FAIL async_reset: got req=%b pc=%h valid=%b addr=%h expected req=0 pc=00 valid=0 addr=00",
                     imem_req, pc, instr_valid, imem_addr);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFF);
        tick();
        reset = 1'b0;
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if ({instr_valid, imm, opcode, imem_req, imem_addr} !== {1'b0, 8'h00, 4'h0, 1'b1, 8'h00}) begin
            errors++;
            $display("[TB] FAIL ack_discarded: got valid=%b imm=%h op=%h req=%b addr=%h expected valid=0 imm=00 op=0 req=1 addr=00",
                     instr_valid, imm, opcode, imem_req, imem_addr);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h6001);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if ({instr_valid, opcode, imm, pc} !== {1'b1, 4'h6, 8'h01, 8'h00}) begin
            errors++;
            $display("[TB] FAIL refetch_after_reset: got valid=%b op=%h imm=%h pc=%h expected valid=1 op=6 imm=01 pc=00",
                     instr_valid, opcode, imm, pc);
        end
    endtask

    task automatic test_ignored_inputs();
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if ({pc, imem_req, imem_addr, instr_valid} !== {8'h01, 1'b1, 8'h01, 1'b0}) begin
            errors++;
            $display("[TB] FAIL cmd_in_fetch: got pc=%h req=%b addr=%h valid=%b expected pc=01 req=1 addr=01 valid=0",
                     pc, imem_req, imem_addr, instr_valid);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h7055);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hEEEE);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if ({pc, imm, opcode, instr_valid, imem_req} !== {8'h01, 8'h55, 4'h7, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL spurious_ack: got pc=%h imm=%h op=%h valid=%b req=%b expected pc=01 imm=55 op=7 valid=1 req=0",
                     pc, imm, opcode, instr_valid, imem_req);
        end
    endtask

    initial begin
        test_reset();
        test_ack_delay();
        test_pc_wrap();
        test_priority();
        test_reset_mid_fetch();
        test_ignored_inputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
